// File: rtl/muxcont_rr_pkg.sv
// Shared constants and types for the crossbar output-port mux controller.
package muxcont_rr_pkg;
  localparam int DEF_PORTW   = 3;
  localparam int DEF_STW     = 2;
  localparam int DEF_UNICAST = 0;
  localparam int DEF_MULTABS = 1;
  // Enable_ polarity: level of rst_ that holds the block in reset
  localparam logic RST_ACT = 1'b0;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;
endpackage

// File: rtl/muxcont_rr_arb.sv
// Round-robin picker: first request strictly after ptr, wrapping modulo NPORT.
module rr_arb_n #(
  parameter int NPORT = 5,
  parameter int PW    = $clog2(NPORT)
) (
  input  logic [NPORT-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [NPORT-1:0] gnt
);
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= NPORT; k++) begin
      for (int i = 0; i < NPORT; i++) begin
        if (!found && req[i] && (i == (int'(ptr) + k) % NPORT)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/muxcont_rr.sv
// Output-port mux controller: round-robin arbitration, wormhole lock until tail,
// credit-gated grants, multicast contention flags and an idle-owner watchdog.
module muxcont_rr
  import muxcont_rr_pkg::*;
#(
  parameter int NPORT   = 5,
  parameter int PORTW   = DEF_PORTW,
  parameter int STW     = DEF_STW,
  parameter int PORTID  = 4,
  parameter int UNICAST = DEF_UNICAST,
  parameter int MULTABS = DEF_MULTABS,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [NPORT-1:0]       req,
  input  logic [NPORT*PORTW-1:0] port,
  input  logic [NPORT*STW-1:0]   multab,
  input  logic [NPORT-1:0]       tail,
  input  logic                   ready,
  output logic [NPORT-1:0]       grt,
  output logic [NPORT-1:0]       sel,
  output logic [NPORT-1:0]       multab_ct,
  output logic                   busy,
  output logic                   tmo
);
  localparam int PW  = $clog2(NPORT);
  localparam int WDW = $clog2(TIMEOUT);

  state_t           state;
  logic [PW-1:0]    owner, rr_ptr, gidx;
  logic [WDW-1:0]   wd_cnt;
  logic [NPORT-1:0] u_req, m_req, any_req, pick, own_oh;
  logic             g_tail;

  for (genvar i = 0; i < NPORT; i++) begin : g_dec
    assign u_req[i] = req[i] && (multab[i*STW +: STW] == STW'(UNICAST))
                             && (port[i*PORTW +: PORTW] == PORTW'(PORTID));
    assign m_req[i] = req[i] && (multab[i*STW +: STW] == STW'(MULTABS));
  end
  assign any_req = u_req | m_req;
  assign own_oh  = {{(NPORT-1){1'b0}}, 1'b1} << owner;

  rr_arb_n #(.NPORT(NPORT), .PW(PW)) u_arb (
    .req (any_req),
    .ptr (rr_ptr),
    .gnt (pick)
  );

  // Grant is held off while in reset so the crossbar never sees a stale pick.
  always_comb begin
    grt = '0;
    if (rst_ != RST_ACT && ready) begin
      if (state == IDLE) grt = pick;
      else               grt = own_oh & any_req;
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NPORT; i++)
      if (grt[i]) gidx = PW'(i);
  end
  assign g_tail    = |(grt & tail);
  assign multab_ct = m_req & ~grt;

  always_ff @(posedge clk or negedge rst_) begin
    if (rst_ == RST_ACT) begin
      state  <= IDLE;
      owner  <= '0;
      sel    <= '0;
      busy   <= 1'b0;
      tmo    <= 1'b0;
      rr_ptr <= PW'(NPORT-1);
      wd_cnt <= '0;
    end else begin
      tmo <= 1'b0;
      case (state)
        IDLE: begin
          sel    <= grt;
          busy   <= 1'b0;
          wd_cnt <= '0;
          if (|grt) begin
            if (g_tail) begin
              rr_ptr <= gidx;
            end else begin
              state <= LOCKED;
              owner <= gidx;
              busy  <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (|grt && tail[owner]) begin
            state  <= IDLE;
            rr_ptr <= owner;
            busy   <= 1'b0;
            sel    <= '0;
            wd_cnt <= '0;
          end else if (!any_req[owner]) begin
            // Owner vanished mid-packet: force release after TIMEOUT idle cycles
            if (wd_cnt == WDW'(TIMEOUT-1)) begin
              state  <= IDLE;
              tmo    <= 1'b1;
              rr_ptr <= owner;
              busy   <= 1'b0;
              sel    <= '0;
              wd_cnt <= '0;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end else begin
            wd_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/muxcont_rr.md
Name: muxcont_rr

Overview:
Parametrised output-port mux controller for the NoC router crossbar, one instance per output port.
- Arbitrates unicast and multicast/absorb requests from NPORT input ports.
- Uses round-robin fairness and wormhole locking until the tail flit is transferred.
- Gates grants with downstream credit and flags multicast contention.
- Adds a lock watchdog that frees the port when an owner vanishes mid-packet.

Parameters:
NPORT, 5, number of input ports (2..16)
PORTW, 3, width of destination-port field per input
STW, 2, width of multicast/absorb status field per input
PORTID, 4, output-port index this instance serves
UNICAST, 0, status code for unicast flit
MULTABS, 1, status code for multicast/absorb flit
TIMEOUT, 64, cycles a lock may persist with owner idle before forced release (>=2)

Ports:
clk  in  1  clock
rst_  in  1  asynchronous active-low reset
req  in  NPORT  per-input flit valid
port  in  NPORT*PORTW  per-input routed output port, input i at [i*PORTW +: PORTW]
multab  in  NPORT*STW  per-input status, input i at [i*STW +: STW]
tail  in  NPORT  per-input flit is packet tail
ready  in  1  downstream credit available this cycle
grt  out  NPORT  one-hot grant (combinational), transfer occurs when grt[i]&ready
sel  out  NPORT  registered one-hot crossbar select (owner)
multab_ct  out  NPORT  multicast requester not granted this cycle
busy  out  1  port locked (registered)
tmo  out  1  one-cycle pulse on watchdog release (registered)

Behaviour:
- u_req[i] = req[i] & multab_i==UNICAST & port_i==PORTID; m_req[i] = req[i] & multab_i==MULTABS; any_req = u_req|m_req.
- Reset (async, rst_=0): state IDLE, owner=0, sel=0, busy=0, tmo=0, rr_ptr=NPORT-1, wd_cnt=0. Outputs derived from these: grt=0, multab_ct=m_req.
- States are IDLE and LOCKED.
- IDLE:
  - grt = round-robin pick of any_req, searching from rr_ptr+1 upward with wrap modulo NPORT.
  - When ready=0, grt=0 (no speculative grant).
  - If grt[i] & ready & ~tail[i]: next state LOCKED, owner=i, sel=onehot(i), busy=1.
  - If grt[i] & ready & tail[i] (single-flit packet): stay IDLE, sel=onehot(i) for one cycle, rr_ptr=i.
  - Otherwise sel=0.
- LOCKED:
  - grt = onehot(owner) & any_req & {NPORT{ready}}; other inputs are never granted.
  - Transfer with tail[owner]: next IDLE, rr_ptr=owner, busy=0, sel=0 the following cycle.
  - wd_cnt increments each cycle any_req[owner]=0 and clears on any owner request.
  - At wd_cnt==TIMEOUT-1 with owner still idle: next IDLE, tmo=1 for one cycle, rr_ptr=owner, busy=0.
- multab_ct = m_req & ~grt, in every state including ready=0.
- Latency: grt in the same cycle as req; sel and busy one cycle after the granting edge.
- grt is always one-hot or zero.
- Simultaneous tail and new requests: the new arbitration happens in the next cycle, so there are no back-to-back packets within one cycle.
- Reset asserted mid-packet: immediate return to reset values; the packet is abandoned.

Decomposition:
- Shared package/define header holds UNICAST/MULTABS codes, STW, PORTW, and the Enable_ polarity constant.
- One natural sub-module, rr_arb_n: parametrised NPORT round-robin picker. Combinational inputs are request vector and rr_ptr; output is one-hot grant.
- FSM, lock, watchdog and multab_ct logic live in the top module.

Test Plan:
1. Reset mid-traffic: rst_ low asynchronously between edges -> sel=0, busy=0, grt=0 immediately; next grant picks input 0 when all request (rr_ptr=NPORT-1).
2. Round-robin: inputs 0,2,4 unicast to port 4, single-flit tails, ready=1 -> grants 0,2,4,0,... on consecutive cycles.
3. Wormhole lock: input 1 sends 4-flit packet, input 3 requests from cycle 2 -> grt=onehot(1) for 4 transfers; input 3 granted the cycle after tail.
4. Credit stall: owner 2 locked, ready=0 for 5 cycles -> grt=0, busy stays 1, wd_cnt stays 0; resumes on ready=1.
5. Multicast contention: input 0 owner, inputs 1 and 3 MULTABS requesting -> multab_ct=5'b01010 every locked cycle.
6. Watchdog: owner 4 drops req mid-packet, TIMEOUT=64 -> tmo pulses after 64 idle cycles, busy=0, next pick starts at input 0.
